mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 49 ++++
 rtl/mem_access_unit_lane_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared constants for the memory access unit.
// Optional build macro MEM_ACCESS_SUBWORD_EN enables byte/halfword accesses.
package mem_access_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned MEM_IDX_HI = 11;
  localparam int unsigned MEM_IDX_LO = 2;
  localparam int unsigned STATE_W    = 3;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD     = 3'd1;
`ifdef MEM_ACCESS_SUBWORD_EN
  localparam logic [STATE_W-1:0] ST_RMW_RD = 3'd2;
`endif
  localparam logic [STATE_W-1:0] ST_WR     = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP   = 3'd4;

  // ReqSize codes
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // Request fields captured at acceptance
  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              zero_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // True when the size is supported and the address is naturally aligned
  function automatic logic req_is_legal(input logic [1:0] size, input logic [1:0] lane);
`ifdef MEM_ACCESS_SUBWORD_EN
    case (size)
      SIZE_B:  return 1'b1;
      SIZE_H:  return ~lane[0];
      SIZE_W:  return (lane == 2'b00);
      default: return 1'b0;
    endcase
`else
    return (size == SIZE_W) && (lane == 2'b00);
`endif
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: little-endian lane extraction for loads and lane merge for stores.
// Sub-word paths exist only with MEM_ACCESS_SUBWORD_EN; otherwise words pass straight through.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              zero_ext,
  input  logic [DATA_W-1:0] read_word,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_word
);

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and sign- or zero-extend it
  always_comb begin
    byte_sel = read_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? read_word[31:16] : read_word[15:0];
    case (size)
      SIZE_B:  load_data = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
      SIZE_H:  load_data = {{16{~zero_ext & half_sel[15]}}, half_sel};
      default: load_data = read_word;
    endcase
  end

  // Replace only the addressed lane(s) of the previously read word
  always_comb begin
    merged_word = old_word;
    case (size)
      SIZE_B: merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
      SIZE_H: begin
        if (lane[1]) merged_word[31:16] = store_data[15:0];
        else         merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end
`else
  logic unused_inputs;

  // Word-only build: data passes through untouched
  always_comb begin
    load_data     = read_word;
    merged_word   = store_data;
    unused_inputs = ^{size, lane, zero_ext, old_word};
  end
`endif

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store sequencer in front of a word data memory.
// Optional build macro MEM_ACCESS_SUBWORD_EN adds byte/half loads and read-modify-write stores.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqUnsigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              RspError,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] ReadData
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  req_t               req_q;
  logic               err_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic [DATA_W-1:0]  rmw_word;
  logic [DATA_W-1:0]  load_data_c;
  logic [DATA_W-1:0]  merged_c;
  logic               legal_c;
  logic               accept_c;

  assign legal_c  = req_is_legal(ReqSize, ReqAddr[1:0]);
  assign accept_c = ReqValid & ReqReady;

`ifdef MEM_ACCESS_SUBWORD_EN
  logic [DATA_W-1:0] rmw_q;

  // Hold the word read during RMW_RD for the merge in WR
  always_ff @(posedge Clk) begin
    if (Reset)                    rmw_q <= '0;
    else if (state_q == ST_RMW_RD) rmw_q <= ReadData;
  end

  assign rmw_word = rmw_q;
`else
  assign rmw_word = '0;
`endif

  mem_lane_align u_lane_align (
    .size        (req_q.size),
    .lane        (req_q.addr[1:0]),
    .zero_ext    (req_q.zero_ext),
    .read_word   (ReadData),
    .old_word    (rmw_word),
    .store_data  (req_q.wdata),
    .load_data   (load_data_c),
    .merged_word (merged_c)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and state-decoded interface signals; Reset forces everything quiet
  always_comb begin
    state_d   = state_q;
    ReqReady  = 1'b0;
    RspValid  = 1'b0;
    RspError  = 1'b0;
    RspData   = rsp_data_q;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (state_q)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (!legal_c)                state_d = ST_RESP;
          else if (!ReqWrite)          state_d = ST_RD;
`ifdef MEM_ACCESS_SUBWORD_EN
          else if (ReqSize != SIZE_W)  state_d = ST_RMW_RD;
`endif
          else                         state_d = ST_WR;
        end
      end
      ST_RD: begin
        MemRead = 1'b1;
        Address = req_q.addr;
        state_d = ST_RESP;
      end
`ifdef MEM_ACCESS_SUBWORD_EN
      ST_RMW_RD: begin
        MemRead = 1'b1;
        Address = req_q.addr;
        state_d = ST_WR;
      end
`endif
      ST_WR: begin
        MemWrite  = 1'b1;
        Address   = req_q.addr;
        WriteData = merged_c;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        RspValid = 1'b1;
        RspError = err_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (Reset) begin
      state_d   = ST_IDLE;
      ReqReady  = 1'b0;
      RspValid  = 1'b0;
      RspError  = 1'b0;
      RspData   = '0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      Address   = '0;
      WriteData = '0;
    end
  end

  // Capture the request at acceptance and the load result in RD
  always_ff @(posedge Clk) begin
    if (Reset) begin
      req_q      <= '0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (accept_c) begin
        req_q <= '{write: ReqWrite, size: ReqSize, zero_ext: ReqUnsigned,
                   addr: ReqAddr, wdata: ReqWData};
        err_q <= ~legal_c;
      end
      if (state_q == ST_RD) rsp_data_q <= load_data_c;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a small word memory model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

`ifdef MEM_ACCESS_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b10;
  logic        ReqUnsigned = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspError;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;

  logic [31:0] mem [0:1023];

  int compared = 0;
  int mismatched = 0;

  int          lat;
  logic [7:0]  rd_mask;
  logic [7:0]  wr_mask;
  logic [31:0] wr_seen;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        both_seen;
  logic [31:0] last_ld;

  mem_access_unit dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .RspValid(RspValid),
    .RspData(RspData), .RspError(RspError), .Address(Address),
    .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData(ReadData)
  );

  always #5 Clk = ~Clk;

  assign ReadData = mem[Address[MEM_IDX_HI:MEM_IDX_LO]];

  always @(posedge Clk) begin
    if (MemWrite) mem[Address[MEM_IDX_HI:MEM_IDX_LO]] <= WriteData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch up to six cycles for the response
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    check({tag, "_ready"}, 32'(ReqReady), 32'd1);
    check({tag, "_idle_rsp"}, 32'(RspValid), 32'd0);
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqUnsigned = u; ReqAddr = a; ReqWData = d;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    lat = 0; rd_mask = '0; wr_mask = '0; wr_seen = '0; rsp_data = '0; rsp_err = 1'b0;
    both_seen = 1'b0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge Clk);
      if (MemRead)  rd_mask[c] = 1'b1;
      if (MemWrite) begin wr_mask[c] = 1'b1; wr_seen = WriteData; end
      if (MemRead && MemWrite) both_seen = 1'b1;
      if (RspValid) begin lat = c; rsp_data = RspData; rsp_err = RspError; end
    end
  endtask

  task automatic expect_rsp(input string tag, input int e_lat, input logic e_err,
                            input logic [31:0] e_data, input logic [7:0] e_rd,
                            input logic [7:0] e_wr);
    check({tag, "_lat"}, 32'(lat), 32'(e_lat));
    check({tag, "_err"}, 32'(rsp_err), 32'(e_err));
    check({tag, "_data"}, rsp_data, e_data);
    check({tag, "_rd"}, 32'(rd_mask), 32'(e_rd));
    check({tag, "_wr"}, 32'(wr_mask), 32'(e_wr));
    check({tag, "_excl"}, 32'(both_seen), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h80017F02;
    mem[2] = 32'h00000369;
    mem[4] = 32'h11223344;

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_ready", 32'(ReqReady), 32'd0);
    check("rst_rspvalid", 32'(RspValid), 32'd0);
    check("rst_rspdata", RspData, 32'd0);
    check("rst_rsperr", 32'(RspError), 32'd0);
    check("rst_memrd", 32'(MemRead), 32'd0);
    check("rst_memwr", 32'(MemWrite), 32'd0);
    check("rst_addr", Address, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    Reset = 1'b0;

    // Word load
    do_req("lw8", 1'b0, SIZE_W, 1'b0, 32'h8, 32'h0);
    expect_rsp("lw8", 2, 1'b0, 32'h00000369, 8'b0000_0010, 8'b0);
    last_ld = 32'h00000369;

    // Misaligned and illegal-size requests; RspData keeps the last load
    do_req("lh5", 1'b0, SIZE_H, 1'b0, 32'h5, 32'h0);
    expect_rsp("lh5", 1, 1'b1, last_ld, 8'b0, 8'b0);
    do_req("lw6", 1'b0, SIZE_W, 1'b0, 32'h6, 32'h0);
    expect_rsp("lw6", 1, 1'b1, last_ld, 8'b0, 8'b0);
    do_req("sz11", 1'b0, SIZE_X, 1'b0, 32'h0, 32'h0);
    expect_rsp("sz11", 1, 1'b1, last_ld, 8'b0, 8'b0);

    // Word store
    do_req("swc", 1'b1, SIZE_W, 1'b0, 32'hC, 32'h80F01234);
    expect_rsp("swc", 2, 1'b0, last_ld, 8'b0, 8'b0000_0010);
    check("swc_wdata", wr_seen, 32'h80F01234);
    check("swc_mem", mem[3], 32'h80F01234);

    // Sub-word loads from 0x80F01234
    do_req("lbf", 1'b0, SIZE_B, 1'b0, 32'hF, 32'h0);
    last_ld = SUB ? 32'hFFFFFF80 : last_ld;
    expect_rsp("lbf", SUB ? 2 : 1, ~SUB, last_ld, SUB ? 8'b10 : 8'b0, 8'b0);
    do_req("lbuf", 1'b0, SIZE_B, 1'b1, 32'hF, 32'h0);
    last_ld = SUB ? 32'h00000080 : last_ld;
    expect_rsp("lbuf", SUB ? 2 : 1, ~SUB, last_ld, SUB ? 8'b10 : 8'b0, 8'b0);
    do_req("lhe", 1'b0, SIZE_H, 1'b0, 32'hE, 32'h0);
    last_ld = SUB ? 32'hFFFF80F0 : last_ld;
    expect_rsp("lhe", SUB ? 2 : 1, ~SUB, last_ld, SUB ? 8'b10 : 8'b0, 8'b0);

    // Byte store via read-modify-write
    do_req("sbd", 1'b1, SIZE_B, 1'b0, 32'hD, 32'h000000AB);
    expect_rsp("sbd", SUB ? 3 : 1, ~SUB, last_ld, SUB ? 8'b0010 : 8'b0, SUB ? 8'b0100 : 8'b0);
    check("sbd_wdata", wr_seen, SUB ? 32'h80F0AB34 : 32'h0);
    check("sbd_mem", mem[3], SUB ? 32'h80F0AB34 : 32'h80F01234);

    // Halfword store, then halfword loads of the merged word
    do_req("sh0", 1'b1, SIZE_H, 1'b0, 32'h0, 32'h0000BEEF);
    expect_rsp("sh0", SUB ? 3 : 1, ~SUB, last_ld, SUB ? 8'b0010 : 8'b0, SUB ? 8'b0100 : 8'b0);
    check("sh0_mem", mem[0], SUB ? 32'h8001BEEF : 32'h80017F02);
    do_req("lh2", 1'b0, SIZE_H, 1'b0, 32'h2, 32'h0);
    last_ld = SUB ? 32'hFFFF8001 : last_ld;
    expect_rsp("lh2", SUB ? 2 : 1, ~SUB, last_ld, SUB ? 8'b10 : 8'b0, 8'b0);
    do_req("lhu0", 1'b0, SIZE_H, 1'b1, 32'h0, 32'h0);
    last_ld = SUB ? 32'h0000BEEF : last_ld;
    expect_rsp("lhu0", SUB ? 2 : 1, ~SUB, last_ld, SUB ? 8'b10 : 8'b0, 8'b0);

    // Reset arriving in the WR cycle aborts the store
    @(negedge Clk);
    check("abort_ready", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = SIZE_W; ReqUnsigned = 1'b0;
    ReqAddr = 32'h10; ReqWData = 32'hDEADBEEF;
    @(posedge Clk);
    #1 ReqValid = 1'b0;
    @(negedge Clk);
    check("abort_wr_state", 32'(MemWrite), 32'd1);
    check("abort_wr_addr", Address, 32'h10);
    Reset = 1'b1;
    #1;
    check("abort_memwr", 32'(MemWrite), 32'd0);
    check("abort_addr", Address, 32'd0);
    check("abort_wdata", WriteData, 32'd0);
    check("abort_ready_rst", 32'(ReqReady), 32'd0);
    check("abort_rspvalid", 32'(RspValid), 32'd0);
    @(posedge Clk);
    #1;
    check("abort_mem", mem[4], 32'h11223344);
    check("abort_rspvalid2", 32'(RspValid), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("abort_ready_after", 32'(ReqReady), 32'd1);
    check("abort_rspvalid3", 32'(RspValid), 32'd0);
    @(negedge Clk);
    check("abort_rspvalid4", 32'(RspValid), 32'd0);
    check("abort_mem2", mem[4], 32'h11223344);

    // Unit is usable again after the abort
    do_req("lw10", 1'b0, SIZE_W, 1'b0, 32'h10, 32'h0);
    expect_rsp("lw10", 2, 1'b0, 32'h11223344, 8'b10, 8'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
